bcd_up_counter: RTL and testbench
=================================

// Module: bcd_up_counter
// PURPOSE
//  Automatic multi-digit BCD up counter; feeds the 7-segment BCD decoder stage.
//  Each digit nibble drives one decoder instance.
//  A clock prescaler generates count ticks. A manual single-step mode uses an edge-detected push-button.
//  Counts 0..MAX_COUNT, wraps to 0 and pulses wrap.
// PARAMETERS
//  DIGITS     2           number of BCD digits; 1..4
//  PRESCALE   50_000_000  clk cycles per automatic count tick; >=2
//  MAX_COUNT  99          terminal decimal value; must be < 10**DIGITS
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  rst        in   1         synchronous, active-high reset
//  en         in   1         count enable; low freezes prescaler and digits
//  clr        in   1         synchronous clear of count and prescaler; no wrap pulse
//  step_mode  in   1         0 = automatic (prescaler ticks); 1 = manual (step edges)
//  step       in   1         push-button, async to clk, active-high
//  bcd        out  4*DIGITS  digit i at bcd[4i+3:4i] ({W,X,Y,Z} of decoder i); digit 0 = units
//  tick       out  1         1-cycle pulse on every accepted increment
//  wrap       out  1         1-cycle pulse when count goes MAX_COUNT -> 0
// BEHAVIOUR
//  - Reset (rst=1 at edge): bcd=0, tick=0, wrap=0, prescaler=0, step synchroniser/edge regs=0.
//  - Priority per edge: rst > clr > en=0 (hold) > increment.
//  - clr=1: bcd=0, prescaler=0, tick=0, wrap=0. Step edge regs keep sampling.
//  - Automatic mode (step_mode=0, en=1):
//    - prescaler counts 0..PRESCALE-1.
//    - Increment request when prescaler==PRESCALE-1; prescaler returns to 0 on that edge.
//    - First increment comes PRESCALE cycles after reset release.
//  - Manual mode (step_mode=1, en=1):
//    - step passes a 2-FF synchroniser, then a rising-edge detector.
//    - One increment per detected 0->1 edge. Latency: 3 clk from step high to bcd change.
//    - Prescaler held at 0 in manual mode.
//  - Mode switch takes effect on the next edge.
//    - Manual -> automatic restarts the prescaler from 0.
//    - A pending step edge is discarded if step_mode=0 on the edge it is detected.
//  - en=0: prescaler, bcd and the edge detector's request are dropped (no queued steps); tick=wrap=0.
//  - Increment:
//    - Registered outputs update on the same edge as the request; tick=1 for that one cycle.
//    - If bcd == MAX_COUNT (BCD compare), bcd=0 and wrap=1 that cycle.
//    - Otherwise ripple BCD carry: digit 9 -> 0 with carry into next digit; non-9 digit +1.
//    - No nibble ever holds 10..15. Carry out of the top digit is impossible while MAX_COUNT < 10**DIGITS.
//  - tick and wrap are registered, never high when rst/clr/en=0 was asserted on the producing edge.
//  - Simultaneous clr and increment request: clr wins, request lost.
// STRUCTURE
//  - Shared package (bcd_pkg): BCD_MAX_DIGIT = 4'd9, typedef bcd_digit_t [3:0],
//    function dec2bcd for converting MAX_COUNT into the BCD compare constant.
//  - Sub-module bcd_digit: one 4-bit BCD cell.
//    - Ports: clk, rst, clr, inc_in, load_zero, q[3:0], carry_out (=inc_in & q==9).
//    - Instantiated DIGITS times via generate; inc_in of digit i = carry_out of digit i-1.
//  - Top holds prescaler, step synchroniser/edge detector, terminal compare, tick/wrap regs.
// TESTING  (run with PRESCALE=4, DIGITS=2, MAX_COUNT=99 unless stated)
//  1. Reset, then en=1, step_mode=0 for 40 clk
//     -> bcd=0x00 until cycle 4, then +1 every 4 clk; bcd=0x09 then 0x10; tick 1-cycle wide.
//  2. Preload by running to 0x99 in auto mode; next tick
//     -> bcd=0x00, wrap=1 exactly one cycle, coincident with tick.
//  3. MAX_COUNT=59: run past 0x59 -> next value 0x00 with wrap; nibbles never exceed 9 (assert every cycle).
//  4. step_mode=1, three step pulses of 5 clk, with 2 clk low between them
//     -> bcd 0x00->0x03, each change 3 clk after step rises; holding step high gives no further counts.
//  5. At bcd=0x37 assert en=0 for 10 clk in auto mode -> bcd holds 0x37, tick=0.
//     Release -> next increment after 4 clk from release at prescaler value held.
//  6. clr and a tick on the same edge at bcd=0x45 -> bcd=0x00, tick=0, wrap=0.
//     Then rst mid-count -> all outputs 0 the following cycle.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants, the digit type and the decimal-to-BCD helper used for the terminal compare.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef logic [3:0] bcd_digit_t;

  // Up to four decimal digits, units in bits [3:0].
  function automatic logic [15:0] dec2bcd(input int unsigned value);
    logic [15:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter cell: steps 0..9 on inc_in and zeroes on rst/clr/load_zero.
// Updates on the edge inc_in is seen; carry_out is combinational, with no backpressure.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc_in,
  input  logic       load_zero,
  output logic [3:0] q,
  output logic       carry_out
);

  bcd_digit_t q_inc;

  assign q_inc     = (q == BCD_MAX_DIGIT) ? '0 : q + 4'd1;
  assign carry_out = inc_in & (q == BCD_MAX_DIGIT);

  always_ff @(posedge clk) begin
    if (rst || clr || load_zero) begin
      q <= '0;
    end else if (inc_in) begin
      q <= q_inc;
    end
  end

endmodule

// File: rtl/bcd_up_counter.sv
// Multi-digit BCD up counter with prescaled auto ticks or synchronised push-button steps.
// Digits, tick and wrap register on the request edge; en=0 freezes it and drops requests, no queueing.
module bcd_up_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int PRESCALE  = 50_000_000,
  parameter int MAX_COUNT = 99
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic                step_mode,
  input  logic                step,
  output logic [4*DIGITS-1:0] bcd,
  output logic                tick,
  output logic                wrap
);

  localparam int                  PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0]       PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [15:0]         MAX_ALL    = dec2bcd(MAX_COUNT);
  localparam logic [4*DIGITS-1:0] MAX_BCD    = MAX_ALL[4*DIGITS-1:0];

  logic [PW-1:0] presc;
  logic          step_s1, step_s2, step_s3;
  logic          step_rise;
  logic          auto_req, man_req, inc_req;
  logic          at_max, wrap_now, top_carry, zero_all;

  // Two-flop synchroniser; step_s3 only remembers the previous synchronised level.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_s3 <= 1'b0;
    end else begin
      step_s1 <= step;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
    end
  end

  assign step_rise = step_s2 & ~step_s3;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc <= '0;
    end else if (en) begin
      if (step_mode || presc == PRESC_LAST) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  assign auto_req = ~step_mode & (presc == PRESC_LAST);
  assign man_req  = step_mode & step_rise;
  assign inc_req  = ~rst & ~clr & en & (auto_req | man_req);

  assign at_max   = (bcd == MAX_BCD);
  assign wrap_now = inc_req & at_max;
  // All-nines below MAX_COUNT is unreachable; zeroing on it keeps every nibble legal regardless.
  assign zero_all = wrap_now | top_carry;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic cin, cout;
    if (i == 0) begin : g_first
      assign cin = inc_req;
    end else begin : g_next
      assign cin = g_dig[i-1].cout;
    end

    bcd_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .inc_in    (cin),
      .load_zero (zero_all),
      .q         (bcd[4*i +: 4]),
      .carry_out (cout)
    );
  end

  assign top_carry = g_dig[DIGITS-1].cout;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= inc_req;
      wrap <= wrap_now;
    end
  end

endmodule

// File: tb/tb_bcd_up_counter.sv
// Directed bench for bcd_up_counter: PRESCALE=4, DIGITS=2, with MAX_COUNT=99 and a 59 instance.
module tb_bcd_up_counter;

  logic       clk;
  logic       rst, en, clr, step_mode, step;
  logic [7:0] bcd, bcd59;
  logic       tick, wrap, tick59, wrap59;
  int         vectors = 0;
  int         miscompares = 0;

  bcd_up_counter #(.DIGITS(2), .PRESCALE(4), .MAX_COUNT(99)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .step_mode(step_mode), .step(step),
    .bcd(bcd), .tick(tick), .wrap(wrap)
  );

  bcd_up_counter #(.DIGITS(2), .PRESCALE(4), .MAX_COUNT(59)) dut59 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .step_mode(step_mode), .step(step),
    .bcd(bcd59), .tick(tick59), .wrap(wrap59)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; step_mode = 1'b0; step = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bcd !== 8'h00) begin miscompares++; $display("FAIL reset_bcd got %h want 00", bcd); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick got %b want 0", tick); end
    vectors++; if (wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap got %b want 0", wrap); end
    vectors++; if (bcd59 !== 8'h00) begin miscompares++; $display("FAIL reset_bcd59 got %h want 00", bcd59); end
    rst = 1'b0;
  endtask

  // Count after k edges since release is k/4; tick on every 4th edge.
  task automatic test_auto_count();
    en = 1'b1; step_mode = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      vectors++; if (bcd !== to_bcd(k / 4)) begin miscompares++; $display("FAIL auto_bcd k=%0d got %h want %h", k, bcd, to_bcd(k / 4)); end
      vectors++; if (tick !== (k % 4 == 0)) begin miscompares++; $display("FAIL auto_tick k=%0d got %b want %b", k, tick, (k % 4 == 0)); end
      vectors++; if (wrap !== 1'b0) begin miscompares++; $display("FAIL auto_wrap k=%0d got %b want 0", k, wrap); end
    end
  endtask

  // Continues from test_auto_count without reset through 99 -> 00.
  task automatic test_wrap();
    for (int k = 41; k <= 404; k++) begin
      logic exp_tick, exp_wrap;
      @(negedge clk);
      exp_tick = (k % 4 == 0);
      exp_wrap = exp_tick && ((k / 4) % 100 == 0);
      vectors++; if (bcd !== to_bcd((k / 4) % 100)) begin miscompares++; $display("FAIL wrap_bcd k=%0d got %h want %h", k, bcd, to_bcd((k / 4) % 100)); end
      vectors++; if (tick !== exp_tick) begin miscompares++; $display("FAIL wrap_tick k=%0d got %b want %b", k, tick, exp_tick); end
      vectors++; if (wrap !== exp_wrap) begin miscompares++; $display("FAIL wrap_pulse k=%0d got %b want %b", k, wrap, exp_wrap); end
    end
  endtask

  task automatic test_max59();
    test_reset();
    en = 1'b1; step_mode = 1'b0;
    for (int k = 1; k <= 250; k++) begin
      logic exp_tick, exp_wrap, nib_ok;
      @(negedge clk);
      exp_tick = (k % 4 == 0);
      exp_wrap = exp_tick && ((k / 4) % 60 == 0);
      nib_ok = (bcd59[3:0] <= 4'd9) && (bcd59[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9) && (bcd[7:4] <= 4'd9);
      vectors++; if (bcd59 !== to_bcd((k / 4) % 60)) begin miscompares++; $display("FAIL m59_bcd k=%0d got %h want %h", k, bcd59, to_bcd((k / 4) % 60)); end
      vectors++; if (tick59 !== exp_tick) begin miscompares++; $display("FAIL m59_tick k=%0d got %b want %b", k, tick59, exp_tick); end
      vectors++; if (wrap59 !== exp_wrap) begin miscompares++; $display("FAIL m59_wrap k=%0d got %b want %b", k, wrap59, exp_wrap); end
      vectors++; if (nib_ok !== 1'b1) begin miscompares++; $display("FAIL nibble_range k=%0d got %h/%h want digits<=9", k, bcd, bcd59); end
    end
  endtask

  // Pulses high on edges 1-5, 8-12, 15-19, then held high from 26: counts land on edges 3, 10, 17, 28.
  task automatic test_manual();
    test_reset();
    en = 1'b1; step_mode = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      int   exp_n;
      logic exp_tick;
      step = ((j >= 1) && (j <= 5)) || ((j >= 8) && (j <= 12)) || ((j >= 15) && (j <= 19)) || (j >= 26);
      @(negedge clk);
      exp_n = int'(j >= 3) + int'(j >= 10) + int'(j >= 17) + int'(j >= 28);
      exp_tick = (j == 3) || (j == 10) || (j == 17) || (j == 28);
      vectors++; if (bcd !== to_bcd(exp_n)) begin miscompares++; $display("FAIL manual_bcd j=%0d got %h want %h", j, bcd, to_bcd(exp_n)); end
      vectors++; if (tick !== exp_tick) begin miscompares++; $display("FAIL manual_tick j=%0d got %b want %b", j, tick, exp_tick); end
    end
    step = 1'b0;
  endtask

  task automatic test_enable_hold();
    test_reset();
    en = 1'b1; step_mode = 1'b0;
    repeat (148) @(negedge clk);
    vectors++; if (bcd !== 8'h37) begin miscompares++; $display("FAIL hold_pre_bcd got %h want 37", bcd); end
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("FAIL hold_pre_tick got %b want 1", tick); end
    en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      vectors++; if (bcd !== 8'h37) begin miscompares++; $display("FAIL hold_bcd i=%0d got %h want 37", i, bcd); end
      vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL hold_tick i=%0d got %b want 0", i, tick); end
    end
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      vectors++; if (bcd !== ((i == 4) ? 8'h38 : 8'h37)) begin miscompares++; $display("FAIL release_bcd i=%0d got %h want %h", i, bcd, (i == 4) ? 8'h38 : 8'h37); end
      vectors++; if (tick !== (i == 4)) begin miscompares++; $display("FAIL release_tick i=%0d got %b want %b", i, tick, (i == 4)); end
    end
  endtask

  task automatic test_clr_and_rst();
    test_reset();
    en = 1'b1; step_mode = 1'b0;
    repeat (183) @(negedge clk);
    vectors++; if (bcd !== 8'h45) begin miscompares++; $display("FAIL clr_pre_bcd got %h want 45", bcd); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vectors++; if (bcd !== 8'h00) begin miscompares++; $display("FAIL clr_bcd got %h want 00", bcd); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL clr_tick got %b want 0", tick); end
    vectors++; if (wrap !== 1'b0) begin miscompares++; $display("FAIL clr_wrap got %b want 0", wrap); end
    repeat (11) @(negedge clk);
    vectors++; if (bcd !== 8'h02) begin miscompares++; $display("FAIL post_clr_bcd got %h want 02", bcd); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (bcd !== 8'h00) begin miscompares++; $display("FAIL midrst_bcd got %h want 00", bcd); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL midrst_tick got %b want 0", tick); end
    vectors++; if (wrap !== 1'b0) begin miscompares++; $display("FAIL midrst_wrap got %b want 0", wrap); end
    repeat (4) @(negedge clk);
    vectors++; if (bcd !== 8'h01) begin miscompares++; $display("FAIL post_rst_bcd got %h want 01", bcd); end
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("FAIL post_rst_tick got %b want 1", tick); end
  endtask

  initial begin
    test_reset();
    test_auto_count();
    test_wrap();
    test_max59();
    test_manual();
    test_enable_hold();
    test_clr_and_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
